// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal storage / shift / count register.
// One state register q; every output is a pure decode of q, so there is no
// input-to-output combinational path. Synchronous reset beats synchronous
// preset, which beats the clock enable; the enable gates only the mode ops.
module univ_shift_reg #(
    parameter int          WIDTH     = 8,
    parameter logic [63:0] RESET_VAL = 64'd0,
    parameter logic [63:0] SET_VAL   = {64{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] Nout,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             tc_up,
    output logic             tc_dn
);

    // Reset and preset values truncated to the register width.
    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SET_V = SET_VAL[WIDTH-1:0];

    // Mode encoding.
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INC  = 3'd6;
    localparam logic [2:0] MODE_DEC  = 3'd7;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mode_q;
    logic [WIDTH-1:0] q_next;

    // Result of the selected mode operation, ignoring reset/set/enable.
    // Arithmetic is WIDTH bits wide, so carry and borrow fall off naturally.
    always_comb begin
        mode_q = q;
        case (mode)
            MODE_HOLD: mode_q = q;
            MODE_LOAD: mode_q = data;
            MODE_SHL:  mode_q = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  mode_q = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:  mode_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  mode_q = {q[0], q[WIDTH-1:1]};
            MODE_INC:  mode_q = q + ONE;
            MODE_DEC:  mode_q = q - ONE;
            default:   mode_q = q;
        endcase
    end

    // Priority select: reset, then preset, then enable-gated mode result.
    always_comb begin
        q_next = q;
        if (reset) begin
            q_next = RST_V;
        end else if (set) begin
            q_next = SET_V;
        end else if (enable) begin
            q_next = mode_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        q <= q_next;
    end

    // Output decodes, all derived from q only.
    always_comb begin
        out       = q;
        Nout      = ~q;
        ser_out_l = q[WIDTH-1];
        ser_out_r = q[0];
        tc_up     = &q;
        tc_dn     = ~|q;
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg with WIDTH=8, RESET_VAL=8'hA5, SET_VAL all ones.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         set;
    logic         enable;
    logic [2:0]   mode;
    logic [W-1:0] data;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] out;
    logic [W-1:0] Nout;
    logic         ser_out_l;
    logic         ser_out_r;
    logic         tc_up;
    logic         tc_dn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_q;

    typedef struct {
        logic         rst;
        logic         st;
        logic         en;
        logic [2:0]   md;
        logic [W-1:0] d;
        logic         sil;
        logic         sir;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    univ_shift_reg #(
        .WIDTH(W),
        .RESET_VAL(64'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set(set),
        .enable(enable),
        .mode(mode),
        .data(data),
        .ser_in_r(ser_in_r),
        .ser_in_l(ser_in_l),
        .out(out),
        .Nout(Nout),
        .ser_out_l(ser_out_l),
        .ser_out_r(ser_out_r),
        .tc_up(tc_up),
        .tc_dn(tc_dn)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol check: mode must be known while enabled.
    always @(posedge clk) begin
        if (enable === 1'b1 && !reset && !set)
            assert (!$isunknown(mode)) else $error("mode is X while enable is high");
    end

    // Reference model of one clock edge.
    function automatic logic [W-1:0] model(input logic [W-1:0] q, input logic rst,
                                           input logic st, input logic en,
                                           input logic [2:0] md, input logic [W-1:0] d,
                                           input logic sil, input logic sir);
        if (rst) return 8'hA5;
        if (st) return 8'hFF;
        if (!en) return q;
        case (md)
            3'd1: return d;
            3'd2: return {q[6:0], sir};
            3'd3: return {sil, q[7:1]};
            3'd4: return {q[6:0], q[7]};
            3'd5: return {q[0], q[7:1]};
            3'd6: return 8'(q + 8'd1);
            3'd7: return 8'(q - 8'd1);
            default: return q;
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input logic st, input logic en,
                                input logic [2:0] md, input logic [W-1:0] d,
                                input logic sil, input logic sir,
                                input logic [W-1:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.st = st; v.en = en; v.md = md; v.d = d;
        v.sil = sil; v.sir = sir; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Pop one expected value and compare every output against it.
    task automatic check_out(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty", name);
            return;
        end
        e = exp_q.pop_front();
        cmp({name, ".out"}, out, e);
        cmp({name, ".Nout"}, Nout, ~e);
        cmp({name, ".ser_out_l"}, {7'd0, ser_out_l}, {7'd0, e[W-1]});
        cmp({name, ".ser_out_r"}, {7'd0, ser_out_r}, {7'd0, e[0]});
        cmp({name, ".tc_up"}, {7'd0, tc_up}, {7'd0, (e == 8'hFF)});
        cmp({name, ".tc_dn"}, {7'd0, tc_dn}, {7'd0, (e == 8'h00)});
    endtask

    // Drive one vector, push its expected result, check after the edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; set = v.st; enable = v.en; mode = v.md;
        data = v.d; ser_in_l = v.sil; ser_in_r = v.sir;
        exp_q.push_back(v.exp);
        m_q = v.exp;
        @(posedge clk);
        #1;
        check_out(v.name);
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; enable = 1'b0; mode = 3'd0;
        data = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
        m_q = '0;

        // Reset / preset priority
        vecs.push_back(mk(1, 1, 1, 3'd6, 8'h00, 0, 0, 8'hA5, "rst_and_set"));
        vecs.push_back(mk(0, 1, 1, 3'd1, 8'h12, 0, 0, 8'hFF, "set_alone"));
        vecs.push_back(mk(0, 0, 1, 3'd1, 8'h00, 0, 0, 8'h00, "load_00"));
        vecs.push_back(mk(0, 1, 0, 3'd1, 8'h3C, 0, 0, 8'hFF, "set_en0"));
        // Load and hold
        vecs.push_back(mk(0, 0, 1, 3'd1, 8'h3C, 0, 0, 8'h3C, "load_3c"));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 3'd1, 8'h00, 0, 0, 8'h3C, "en0_hold"));
        vecs.push_back(mk(0, 0, 1, 3'd0, 8'h55, 1, 1, 8'h3C, "mode_hold"));
        // Shifts
        vecs.push_back(mk(0, 0, 1, 3'd1, 8'h81, 0, 0, 8'h81, "load_81"));
        vecs.push_back(mk(0, 0, 1, 3'd2, 8'h00, 0, 1, 8'h03, "shl_1"));
        vecs.push_back(mk(0, 0, 1, 3'd3, 8'h00, 0, 1, 8'h01, "shr_0"));
        vecs.push_back(mk(0, 0, 1, 3'd3, 8'h00, 1, 0, 8'h80, "shr_1"));
        // Rotates
        vecs.push_back(mk(0, 0, 1, 3'd1, 8'h81, 0, 0, 8'h81, "load_81b"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 0, 0, 8'h03, "rol"));
        vecs.push_back(mk(0, 0, 1, 3'd5, 8'h00, 1, 0, 8'h81, "ror"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h03, "rol8_1"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h06, "rol8_2"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h0C, "rol8_3"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h18, "rol8_4"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h30, "rol8_5"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h60, "rol8_6"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'hC0, "rol8_7"));
        vecs.push_back(mk(0, 0, 1, 3'd4, 8'h00, 1, 1, 8'h81, "rol8_8"));
        // Count wrap
        vecs.push_back(mk(0, 0, 1, 3'd1, 8'hFE, 0, 0, 8'hFE, "load_fe"));
        vecs.push_back(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'hFF, "inc_ff"));
        vecs.push_back(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'h00, "inc_wrap"));
        vecs.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 0, 8'hFF, "dec_wrap"));
        vecs.push_back(mk(0, 0, 1, 3'd7, 8'h00, 0, 0, 8'hFE, "dec_fe"));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-count: reset on the 4th count edge, then resume.
        apply(mk(0, 0, 1, 3'd1, 8'h10, 0, 0, 8'h10, "mc_load"));
        apply(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'h11, "mc_e1"));
        apply(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'h12, "mc_e2"));
        apply(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'h13, "mc_e3"));
        apply(mk(1, 0, 1, 3'd6, 8'h00, 0, 0, 8'hA5, "mc_e4_rst"));
        apply(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'hA6, "mc_resume1"));
        apply(mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 8'hA7, "mc_resume2"));

        // Back-to-back random operations against the model.
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.rst = ($urandom_range(0, 31) == 0);
            v.st  = ($urandom_range(0, 31) == 0);
            v.en  = ($urandom_range(0, 7) != 0);
            v.md  = 3'($urandom_range(0, 7));
            v.d   = 8'($urandom_range(0, 255));
            v.sil = 1'($urandom_range(0, 1));
            v.sir = 1'($urandom_range(0, 1));
            v.exp = model(m_q, v.rst, v.st, v.en, v.md, v.d, v.sil, v.sir);
            v.name = "rand";
            apply(v);
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d expected values not consumed, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
